// File: rtl/div32_seq_if.sv
// rtl/div32_seq_if.sv - start/busy/done handshake and operand/result bundle for div32_seq
interface div32_seq_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - 32-bit unsigned restoring divider, one quotient bit per clock
module div32_seq (
    input  logic        clk,
    input  logic        rst,
    div32_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_dbz;

    logic        w_accept;
    logic        w_zero;
    logic [32:0] w_rem_sh;
    logic        w_qbit;
    logic [31:0] w_rem_nx;

    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_zero   = (bus.divisor == 32'd0);

    // The captured dividend shifts out MSB-first and quotient bits shift in at
    // the bottom, so after 32 steps r_dvd holds the quotient. The difference
    // always fits in 32 bits when it is kept, because rem < divisor.
    always_comb begin
        w_rem_sh = {r_rem, r_dvd[31]};
        w_qbit   = (w_rem_sh >= {1'b0, r_dvs});
        w_rem_nx = w_qbit ? (w_rem_sh[31:0] - r_dvs) : w_rem_sh[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)               w_next = w_zero ? S_DONE : S_RUN;
                else if (r_state == S_DONE) w_next = S_IDLE;
            end
            S_RUN:   if (r_cnt == 5'd31) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= 32'd0;
            r_dvs       <= 32'd0;
            r_rem       <= 32'd0;
            r_cnt       <= 5'd0;
            r_quotient  <= 32'd0;
            r_remainder <= 32'd0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_zero) begin
                r_quotient  <= 32'hFFFF_FFFF;
                r_remainder <= bus.dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_dvd <= bus.dividend;
                r_dvs <= bus.divisor;
                r_rem <= 32'd0;
                r_cnt <= 5'd0;
                r_dbz <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_nx;
            r_dvd <= {r_dvd[30:0], w_qbit};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_quotient  <= {r_dvd[30:0], w_qbit};
                r_remainder <= w_rem_nx;
            end
        end
    end

    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - randomized self-checking bench for div32_seq
module tb_div32_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total    = 0;

    div32_seq_if u_if ();
    div32_seq u_dut (.clk(clk), .rst(rst), .bus(u_if));

    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Drives one start at the current negedge, returns results sampled in the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic z,
                          output int lat, output int bcnt, output bit ovl);
        u_if.start = 1'b1; u_if.dividend = a; u_if.divisor = b;
        @(negedge clk);
        u_if.start = 1'b0; u_if.dividend = $urandom; u_if.divisor = $urandom;
        lat = 1; bcnt = 0; ovl = 1'b0;
        while (!u_if.done && lat < 100) begin
            if (u_if.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (u_if.busy && u_if.done) ovl = 1'b1;
        q = u_if.quotient; r = u_if.remainder; z = u_if.div_by_zero;
    endtask

    task automatic test_reset();
        u_if.start = 1'b0; u_if.dividend = '0; u_if.divisor = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({u_if.busy, u_if.done, u_if.quotient, u_if.remainder, u_if.div_by_zero} !== 67'd0) begin
            $display("FAIL reset_outputs: got busy=%0b done=%0b q=%h r=%h z=%0b, want all 0",
                     u_if.busy, u_if.done, u_if.quotient, u_if.remainder, u_if.div_by_zero);
        end else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] q, r; logic z; int lat, bcnt; bit ovl;
        run_op(32'd100, 32'd7, q, r, z, lat, bcnt, ovl);
        total++;
        if (lat !== 33) $display("FAIL basic_latency: got %0d, want 33", lat); else pass_cnt++;
        total++;
        if (bcnt !== 32) $display("FAIL basic_busy_cycles: got %0d, want 32", bcnt); else pass_cnt++;
        total++;
        if ({q, r, z, ovl} !== {32'd14, 32'd2, 1'b0, 1'b0})
            $display("FAIL basic_100_7: got q=%0d r=%0d z=%0b ovl=%0b, want q=14 r=2 z=0 ovl=0", q, r, z, ovl);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total++;
        if ({u_if.quotient, u_if.remainder, u_if.done, u_if.busy} !== {32'd14, 32'd2, 2'b00})
            $display("FAIL result_hold: got q=%0d r=%0d done=%0b busy=%0b, want 14 2 0 0",
                     u_if.quotient, u_if.remainder, u_if.done, u_if.busy);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        logic [31:0] a_tab [3] = '{32'hFFFF_FFFF, 32'd3, 32'h8000_0000};
        logic [31:0] b_tab [3] = '{32'd1, 32'd10, 32'hFFFF_FFFF};
        logic [31:0] q, r, eq, er; logic z, ez; int lat, bcnt; bit ovl;
        for (int i = 0; i < 3; i++) begin
            ref_div(a_tab[i], b_tab[i], eq, er, ez);
            run_op(a_tab[i], b_tab[i], q, r, z, lat, bcnt, ovl);
            total++;
            if ({q, r, z, lat} !== {eq, er, ez, 32'd33})
                $display("FAIL edge_%0d: got q=%h r=%h z=%0b lat=%0d, want q=%h r=%h z=%0b lat=33",
                         i, q, r, z, lat, eq, er, ez);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic z; int lat, bcnt; bit ovl;
        @(negedge clk);
        run_op(32'd5, 32'd0, q, r, z, lat, bcnt, ovl);
        total++;
        if ({lat, bcnt} !== {32'd1, 32'd0})
            $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d, want 1 0", lat, bcnt);
        else pass_cnt++;
        total++;
        if ({q, r, z} !== {32'hFFFF_FFFF, 32'd5, 1'b1})
            $display("FAIL dbz_result: got q=%h r=%h z=%0b, want ffffffff 5 1", q, r, z);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({u_if.div_by_zero, u_if.busy, u_if.done} !== 3'b100)
            $display("FAIL dbz_sticky: got z=%0b busy=%0b done=%0b, want 1 0 0",
                     u_if.div_by_zero, u_if.busy, u_if.done);
        else pass_cnt++;
        run_op(32'd9, 32'd3, q, r, z, lat, bcnt, ovl);
        total++;
        if ({q, r, z, lat} !== {32'd3, 32'd0, 1'b0, 32'd33})
            $display("FAIL dbz_clear: got q=%0d r=%0d z=%0b lat=%0d, want 3 0 0 33", q, r, z, lat);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int k;
        @(negedge clk);
        u_if.start = 1'b1; u_if.dividend = 32'd1000; u_if.divisor = 32'd3;
        @(negedge clk);
        u_if.start = 1'b0; k = 1;
        while (!u_if.done && k < 100) begin
            if (k == 10) begin u_if.start = 1'b1; u_if.dividend = 32'd50; u_if.divisor = 32'd5; end
            else         u_if.start = 1'b0;
            @(negedge clk);
            k++;
        end
        u_if.start = 1'b0;
        total++;
        if ({u_if.quotient, u_if.remainder, k} !== {32'd333, 32'd1, 32'd33})
            $display("FAIL start_in_run: got q=%0d r=%0d lat=%0d, want 333 1 33",
                     u_if.quotient, u_if.remainder, k);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] q, r; logic z; int lat, bcnt; bit ovl; int seen;
        @(negedge clk);
        u_if.start = 1'b1; u_if.dividend = 32'd1000; u_if.divisor = 32'd3;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (11) @(negedge clk);
        total++;
        if (u_if.busy !== 1'b1) $display("FAIL midrun_busy: got %0b, want 1", u_if.busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if ({u_if.busy, u_if.done, u_if.quotient, u_if.remainder, u_if.div_by_zero} !== 67'd0)
            $display("FAIL midrun_reset: got busy=%0b done=%0b q=%h r=%h z=%0b, want all 0",
                     u_if.busy, u_if.done, u_if.quotient, u_if.remainder, u_if.div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (u_if.done) seen++; end
        total++;
        if (seen !== 0) $display("FAIL lost_op_done: got %0d done pulses, want 0", seen); else pass_cnt++;
        run_op(32'd7, 32'd2, q, r, z, lat, bcnt, ovl);
        total++;
        if ({q, r, z, lat} !== {32'd3, 32'd1, 1'b0, 32'd33})
            $display("FAIL after_reset: got q=%0d r=%0d z=%0b lat=%0d, want 3 1 0 33", q, r, z, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r; logic z; int lat, bcnt; bit ovl;
        @(negedge clk);
        run_op(32'd20, 32'd6, q, r, z, lat, bcnt, ovl);
        total++;
        if ({q, r, lat} !== {32'd3, 32'd2, 32'd33})
            $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d, want 3 2 33", q, r, lat);
        else pass_cnt++;
        run_op(32'd21, 32'd4, q, r, z, lat, bcnt, ovl);
        total++;
        if ({q, r, lat, bcnt, ovl} !== {32'd5, 32'd1, 32'd33, 32'd32, 1'b0})
            $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d busy_cycles=%0d ovl=%0b, want 5 1 33 32 0",
                     q, r, lat, bcnt, ovl);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er; logic z, ez; int lat, bcnt, elat; bit ovl;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(a, b, eq, er, ez);
            elat = (b == 32'd0) ? 1 : 33;
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            run_op(a, b, q, r, z, lat, bcnt, ovl);
            total++;
            if ({q, r, z, lat, ovl} !== {eq, er, ez, elat, 1'b0})
                $display("FAIL random_%0d %h/%h: got q=%h r=%h z=%0b lat=%0d ovl=%0b, want q=%h r=%h z=%0b lat=%0d",
                         i, a, b, q, r, z, lat, ovl, eq, er, ez, elat);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
